// File: rtl/param_alu_pkg.sv
// Shared opcode, state and comparison-code definitions for the serial ALU.
package param_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_PAR  = 3'b010,
    OP_COMP = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EXEC,
    DONE
  } alu_state_e;

  localparam logic [1:0] COMP_EQ = 2'd0;
  localparam logic [1:0] COMP_GT = 2'd1;
  localparam logic [1:0] COMP_LT = 2'd2;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: start loads operands, done pulses once the
// 2*WIDTH product is complete, WIDTH-1 cycles after the start edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               done_q;

  // The start edge already folds in multiplier bit 0, so only WIDTH-1
  // further iterations remain.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
        mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
        mplier_q <= b_i >> 1;
        cnt_q    <= CW'(WIDTH-1);
      end else if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/param_serial_alu.sv
// Serial-opcode ALU: frames an LSB-first opcode plus two operands, executes,
// and returns a registered result. Define PARAM_ALU_SAT_EN for saturating ADD/SUB/MUL.
//
// state | meaning
// IDLE  | waiting for opcode_valid; first frame cycle captures A and opcode bit 0
// SHIFT | shifting remaining opcode bits, B on frame cycle 1; valid drop aborts
// EXEC  | one cycle for simple ops, multiplier run for MUL, illegal check
// DONE  | done or illegal pulse with updated result, then back to IDLE
module param_serial_alu
  import param_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  illegal
);

  localparam int CW = $clog2(OPCODE_BITS) + 1;

  alu_state_e             state_q;
  logic [OPCODE_BITS-1:0] op_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q, result_q;
  logic                   ovf_q, done_q, illegal_q, busy_q;

  logic [OPCODE_BITS-1:0]  op_next;
  logic                    next_upper_nz, op_upper_nz, last_bit, mul_start, mul_done;
  logic [2*DATA_WIDTH-1:0] mul_prod;
  logic [DATA_WIDTH:0]     sum, diff;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_ovf;

  assign op_next       = {opcode, op_q[OPCODE_BITS-1:1]};
  assign next_upper_nz = |(op_next >> 3);
  assign op_upper_nz   = |(op_q >> 3);
  assign last_bit      = (cnt_q == CW'(OPCODE_BITS-1));

  // Launch the multiplier on the final frame bit so it runs exactly DATA_WIDTH EXEC cycles.
  assign mul_start = (state_q == SHIFT) && opcode_valid && last_bit &&
                     !next_upper_nz && (op_next[2:0] == OP_MUL);

  alu_mul_seq #(.WIDTH(DATA_WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (a_q),
    .b_i       (b_q),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    case (alu_op_e'(op_q[2:0]))
      OP_ADD: begin
        alu_res = sum[DATA_WIDTH-1:0];
        alu_ovf = sum[DATA_WIDTH];
`ifdef PARAM_ALU_SAT_EN
        if (sum[DATA_WIDTH]) alu_res = '1;
`endif
      end
      OP_SUB: begin
        alu_res = diff[DATA_WIDTH-1:0];
        alu_ovf = diff[DATA_WIDTH];
`ifdef PARAM_ALU_SAT_EN
        if (diff[DATA_WIDTH]) alu_res = '0;
`endif
      end
      OP_PAR:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ^(a_q ^ b_q)};
      OP_COMP: begin
        if (a_q > b_q)      alu_res = {{(DATA_WIDTH-2){1'b0}}, COMP_GT};
        else if (a_q < b_q) alu_res = {{(DATA_WIDTH-2){1'b0}}, COMP_LT};
        else                alu_res = {{(DATA_WIDTH-2){1'b0}}, COMP_EQ};
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_MUL: begin
        alu_res = mul_prod[DATA_WIDTH-1:0];
        alu_ovf = |mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef PARAM_ALU_SAT_EN
        if (alu_ovf) alu_res = '1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (opcode_valid) begin
            op_q    <= op_next;
            a_q     <= data;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!opcode_valid) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            op_q <= op_next;
            if (cnt_q == CW'(1)) b_q <= data;
            if (last_bit) begin
              cnt_q   <= '0;
              state_q <= EXEC;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        EXEC: begin
          if (op_upper_nz) begin
            illegal_q <= 1'b1;
            state_q   <= DONE;
          end else if ((op_q[2:0] != OP_MUL) || mul_done) begin
            result_q <= alu_res;
            ovf_q    <= alu_ovf;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_param_serial_alu.sv
// Directed bench for param_serial_alu: one 3-bit-opcode and one 4-bit-opcode instance.
module tb_param_serial_alu;

`ifdef PARAM_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst0, rst1, v0, v1, ob0, ob1;
  logic [7:0] d0, d1;
  logic busy0, done0, ovf0, ill0, busy1, done1, ovf1, ill1;
  logic [7:0] res0, res1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_serial_alu #(.DATA_WIDTH(8), .OPCODE_BITS(3)) u_dut0 (
    .clk(clk), .reset(rst0), .opcode_valid(v0), .opcode(ob0), .data(d0),
    .busy(busy0), .done(done0), .result(res0), .overflow(ovf0), .illegal(ill0)
  );

  param_serial_alu #(.DATA_WIDTH(8), .OPCODE_BITS(4)) u_dut1 (
    .clk(clk), .reset(rst1), .opcode_valid(v1), .opcode(ob1), .data(d1),
    .busy(busy1), .done(done1), .result(res1), .overflow(ovf1), .illegal(ill1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic b, input logic [7:0] d);
    if (s == 0) begin v0 = v; ob0 = b; d0 = d; end
    else        begin v1 = v; ob1 = b; d1 = d; end
  endtask

  task automatic send_frame(input int s, input logic [3:0] op, input int nbits,
                            input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      drive(s, 1'b1, op[i], (i == 0) ? a : ((i == 1) ? b : 8'h00));
    end
  endtask

  // lat counts cycles after the final frame bit; -1 when nothing responds.
  task automatic wait_resp(input int s, input int pulse_at, output int lat,
                           output logic got_done, output logic got_ill, output logic busy_ok);
    lat = -1; got_done = 1'b0; got_ill = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == pulse_at) drive(s, 1'b1, 1'b1, 8'hA5);
      else               drive(s, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      if (!((s == 0) ? busy0 : busy1)) busy_ok = 1'b0;
      if ((s == 0) ? (done0 || ill0) : (done1 || ill1)) begin
        lat      = c;
        got_done = (s == 0) ? done0 : done1;
        got_ill  = (s == 0) ? ill0 : ill1;
        break;
      end
    end
  endtask

  task automatic run_op(input int s, input string tag, input logic [3:0] op, input int nbits,
                        input logic [7:0] a, input logic [7:0] b, input int pulse_at,
                        input int exp_lat, input logic [7:0] exp_res, input logic exp_ovf);
    int lat;
    logic gd, gi, bok;
    send_frame(s, op, nbits, a, b);
    wait_resp(s, pulse_at, lat, gd, gi, bok);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " done"}, gd, 1'b1);
    chk({tag, " illegal"}, gi, 1'b0);
    chk({tag, " busy"}, bok, 1'b1);
    chk({tag, " result"}, (s == 0) ? res0 : res1, exp_res);
    chk({tag, " overflow"}, (s == 0) ? ovf0 : ovf1, exp_ovf);
  endtask

  initial begin
    int lat;
    logic gd, gi, bok, saw;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("rst busy", busy0, 1'b0);
    chk("rst done", done0, 1'b0);
    chk("rst illegal", ill0, 1'b0);
    chk("rst result", res0, 8'h00);
    chk("rst overflow", ovf0, 1'b0);
    chk("rst busy1", busy1, 1'b0);

    run_op(0, "add carry", 4'b0000, 3, 8'hF0, 8'h20, 0, 2, SAT ? 8'hFF : 8'h10, 1'b1);
    @(negedge clk);
    chk("add done pulse", done0, 1'b0);
    chk("add busy clear", busy0, 1'b0);
    run_op(0, "add plain", 4'b0000, 3, 8'h12, 8'h34, 0, 2, 8'h46, 1'b0);
    run_op(0, "sub plain", 4'b0001, 3, 8'h09, 8'h05, 0, 2, 8'h04, 1'b0);
    run_op(0, "par even", 4'b0010, 3, 8'hC3, 8'h5A, 0, 2, 8'h00, 1'b0);
    run_op(0, "par odd", 4'b0010, 3, 8'h07, 8'h00, 0, 2, 8'h01, 1'b0);
    run_op(0, "and", 4'b0100, 3, 8'hC3, 8'h5A, 0, 2, 8'h42, 1'b0);
    run_op(0, "or", 4'b0101, 3, 8'hC3, 8'h5A, 0, 2, 8'hDB, 1'b0);
    run_op(0, "xor", 4'b0110, 3, 8'hC3, 8'h5A, 0, 2, 8'h99, 1'b0);
    run_op(0, "comp lt", 4'b0011, 3, 8'h05, 8'h09, 0, 2, 8'h02, 1'b0);
    run_op(0, "comp gt", 4'b0011, 3, 8'h09, 8'h05, 0, 2, 8'h01, 1'b0);
    run_op(0, "comp eq", 4'b0011, 3, 8'h7A, 8'h7A, 0, 2, 8'h00, 1'b0);
    run_op(0, "mul ovf", 4'b0111, 3, 8'h10, 8'h11, 0, 9, SAT ? 8'hFF : 8'h10, 1'b1);
    run_op(0, "mul small", 4'b0111, 3, 8'h03, 8'h05, 0, 9, 8'h0F, 1'b0);

    send_frame(0, 4'b0000, 2, 8'h55, 8'h66);
    wait_resp(0, 0, lat, gd, gi, bok);
    chk("abort no response", lat, -1);
    chk("abort result held", res0, 8'h0F);
    chk("abort busy", busy0, 1'b0);
    run_op(0, "after abort", 4'b0000, 3, 8'h01, 8'h02, 0, 2, 8'h03, 1'b0);

    run_op(0, "mul busy pulse", 4'b0111, 3, 8'h03, 8'h05, 3, 9, 8'h0F, 1'b0);
    run_op(0, "b2b sub borrow", 4'b0001, 3, 8'h02, 8'h03, 0, 2, SAT ? 8'h00 : 8'hFF, 1'b1);

    run_op(0, "pre rst add", 4'b0000, 3, 8'h21, 8'h10, 0, 2, 8'h31, 1'b0);
    send_frame(0, 4'b0111, 3, 8'h10, 8'h11);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 8'h00);
      rst0 = (c == 4);
      @(negedge clk);
    end
    chk("midmul rst busy", busy0, 1'b0);
    chk("midmul rst result", res0, 8'h00);
    chk("midmul rst overflow", ovf0, 1'b0);
    chk("midmul rst done", done0, 1'b0);
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done0 || ill0) saw = 1'b1;
    end
    chk("midmul no late done", saw, 1'b0);

    run_op(1, "ob4 add", 4'b0000, 4, 8'h03, 8'h04, 0, 2, 8'h07, 1'b0);
    send_frame(1, 4'b1000, 4, 8'h11, 8'h22);
    wait_resp(1, 0, lat, gd, gi, bok);
    chk("ob4 illegal latency", lat, 2);
    chk("ob4 illegal pulse", gi, 1'b1);
    chk("ob4 illegal no done", gd, 1'b0);
    chk("ob4 illegal result held", res1, 8'h07);
    @(negedge clk);
    chk("ob4 illegal one cycle", ill1, 1'b0);
    run_op(1, "ob4 mul", 4'b0111, 4, 8'h06, 8'h07, 0, 9, 8'h2A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
